// File: rtl/mouse_ctrl.sv
// mouse_ctrl
// Host-side sequencer for a PS/2 mouse: runs the reset / enable command
// handshake through the byte transmitter, then assembles 3-byte stream-mode
// packets from the byte receiver into button and movement reports.
module mouse_ctrl #(
  parameter int TIMEOUT_CYCLES = 1_000_000,
  parameter int GAP_CYCLES     = 100_000,
  parameter int RETRY_MAX      = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] i_rx_byte,
  input  logic       i_rx_valid,
  output logic [7:0] o_tx_byte,
  output logic       o_tx_start,
  input  logic       i_tx_busy,
  input  logic       i_tx_done,
  output logic       o_ready,
  output logic       o_err,
  output logic       o_pkt_valid,
  output logic [2:0] o_btn,
  output logic [8:0] o_dx,
  output logic [8:0] o_dy,
  output logic       o_ovf
);

  // One timer serves both the init response timeout and the inter-byte gap,
  // so it has to be wide enough for whichever limit is larger.
  localparam int MaxWait = (TIMEOUT_CYCLES > GAP_CYCLES) ? TIMEOUT_CYCLES : GAP_CYCLES;
  localparam int TW      = $clog2(MaxWait + 1);
  localparam int RW      = (RETRY_MAX > 1) ? $clog2(RETRY_MAX) : 1;

  localparam logic [7:0] CmdReset  = 8'hFF;
  localparam logic [7:0] CmdEnable = 8'hF4;
  localparam logic [7:0] RspAck    = 8'hFA;
  localparam logic [7:0] RspBat    = 8'hAA;
  localparam logic [7:0] RspId     = 8'h00;

  typedef enum logic [3:0] {
    SEND_RST,
    WAIT_ACK1,
    WAIT_BAT,
    WAIT_ID,
    SEND_EN,
    WAIT_ACK2,
    PKT_B0,
    PKT_B1,
    PKT_B2,
    FAIL
  } state_t;

  state_t         state_q;
  logic [TW-1:0]  timer_q;
  logic [TW-1:0]  timer_d;
  logic [RW-1:0]  retry_q;
  logic           sent_q;

  // Only the fields of byte 0 that feed the report are kept; bit 3 is the
  // always-one sync marker and carries no information once checked.
  logic [2:0]     b0Btn_q;
  logic           b0Xs_q;
  logic           b0Ys_q;
  logic           b0Ovf_q;
  logic [7:0]     b1_q;

  logic           isSend;
  logic           isWait;
  logic           isInit;
  logic [7:0]     expByte;
  logic [7:0]     cmdByte;
  logic           rxHit;
  logic           rxMiss;
  logic           txFinish;
  logic           timedOut;
  logic           gapOut;
  logic           initFail;
  logic           retryLast;

  // Decode the current state into the checks the sequencer needs this cycle.
  // A received byte or a completed transmit always wins over a timeout that
  // lands in the same cycle.
  always_comb begin
    isSend    = (state_q == SEND_RST) || (state_q == SEND_EN);
    isWait    = (state_q == WAIT_ACK1) || (state_q == WAIT_BAT) ||
                (state_q == WAIT_ID)   || (state_q == WAIT_ACK2);
    isInit    = isSend || isWait;

    expByte   = RspAck;
    case (state_q)
      WAIT_BAT: expByte = RspBat;
      WAIT_ID:  expByte = RspId;
      default:  expByte = RspAck;
    endcase

    cmdByte   = (state_q == SEND_EN) ? CmdEnable : CmdReset;

    rxHit     = i_rx_valid && isWait && (i_rx_byte == expByte);
    rxMiss    = i_rx_valid && isWait && (i_rx_byte != expByte);
    txFinish  = isSend && sent_q && i_tx_done;
    timedOut  = (timer_q >= TW'(TIMEOUT_CYCLES));
    gapOut    = (timer_q >= TW'(GAP_CYCLES));
    initFail  = rxMiss || (isInit && timedOut && !rxHit && !txFinish);
    retryLast = (retry_q == RW'(RETRY_MAX - 1));

    timer_d   = (timer_q == '1) ? timer_q : timer_q + TW'(1);
  end

  // Main sequencer: init handshake with retries, then packet assembly.
  // The timer free-runs (saturating) and is cleared on any state change or
  // accepted byte by overriding the default below.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= SEND_RST;
      timer_q     <= '0;
      retry_q     <= '0;
      sent_q      <= 1'b0;
      b0Btn_q     <= '0;
      b0Xs_q      <= 1'b0;
      b0Ys_q      <= 1'b0;
      b0Ovf_q     <= 1'b0;
      b1_q        <= '0;
      o_tx_byte   <= '0;
      o_tx_start  <= 1'b0;
      o_ready     <= 1'b0;
      o_err       <= 1'b0;
      o_pkt_valid <= 1'b0;
      o_btn       <= '0;
      o_dx        <= '0;
      o_dy        <= '0;
      o_ovf       <= 1'b0;
    end else begin
      o_tx_start  <= 1'b0;
      o_pkt_valid <= 1'b0;
      timer_q     <= timer_d;

      if (initFail) begin
        timer_q <= '0;
        sent_q  <= 1'b0;
        if (retryLast) begin
          state_q <= FAIL;
          o_err   <= 1'b1;
        end else begin
          retry_q <= retry_q + RW'(1);
          state_q <= SEND_RST;
        end
      end else begin
        case (state_q)
          SEND_RST, SEND_EN: begin
            // Exactly one request per visit, issued once the link is idle.
            if (!sent_q && !i_tx_busy) begin
              o_tx_start <= 1'b1;
              o_tx_byte  <= cmdByte;
              sent_q     <= 1'b1;
            end
            if (txFinish) begin
              sent_q  <= 1'b0;
              timer_q <= '0;
              state_q <= (state_q == SEND_RST) ? WAIT_ACK1 : WAIT_ACK2;
            end
          end

          WAIT_ACK1: begin
            if (rxHit) begin
              state_q <= WAIT_BAT;
              timer_q <= '0;
            end
          end

          WAIT_BAT: begin
            if (rxHit) begin
              state_q <= WAIT_ID;
              timer_q <= '0;
            end
          end

          WAIT_ID: begin
            if (rxHit) begin
              state_q <= SEND_EN;
              timer_q <= '0;
            end
          end

          WAIT_ACK2: begin
            if (rxHit) begin
              state_q <= PKT_B0;
              o_ready <= 1'b1;
              retry_q <= '0;
              timer_q <= '0;
            end
          end

          PKT_B0: begin
            // A first byte must carry the bit-3 marker; anything else is
            // dropped so the stream realigns on the next marked byte.
            if (i_rx_valid) begin
              timer_q <= '0;
              if (i_rx_byte[3]) begin
                b0Btn_q <= i_rx_byte[2:0];
                b0Xs_q  <= i_rx_byte[4];
                b0Ys_q  <= i_rx_byte[5];
                b0Ovf_q <= i_rx_byte[6] | i_rx_byte[7];
                state_q <= PKT_B1;
              end
            end
          end

          PKT_B1: begin
            if (i_rx_valid) begin
              b1_q    <= i_rx_byte;
              state_q <= PKT_B2;
              timer_q <= '0;
            end else if (gapOut) begin
              state_q <= PKT_B0;
              timer_q <= '0;
            end
          end

          PKT_B2: begin
            if (i_rx_valid) begin
              o_pkt_valid <= 1'b1;
              o_btn       <= b0Btn_q;
              o_ovf       <= b0Ovf_q;
              o_dx        <= b0Ovf_q ? 9'd0 : {b0Xs_q, b1_q};
              o_dy        <= b0Ovf_q ? 9'd0 : {b0Ys_q, i_rx_byte};
              state_q     <= PKT_B0;
              timer_q     <= '0;
            end else if (gapOut) begin
              state_q <= PKT_B0;
              timer_q <= '0;
            end
          end

          FAIL: begin
            state_q <= FAIL;
          end

          default: begin
            state_q <= SEND_RST;
            timer_q <= '0;
            sent_q  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mouse_ctrl.sv
// tb_mouse_ctrl
// Self-checking bench for mouse_ctrl: a small transmitter model answers
// command requests, tests play the mouse side, and scoreboards hold the
// expected command bytes and packet reports.
module tb_mouse_ctrl;

  localparam int TO   = 300;
  localparam int GAP  = 40;
  localparam int RMAX = 3;

  logic       clk;
  logic       rst_n;
  logic [7:0] i_rx_byte;
  logic       i_rx_valid;
  logic [7:0] o_tx_byte;
  logic       o_tx_start;
  logic       i_tx_busy;
  logic       i_tx_done = 1'b0;
  logic       o_ready;
  logic       o_err;
  logic       o_pkt_valid;
  logic [2:0] o_btn;
  logic [8:0] o_dx;
  logic [8:0] o_dy;
  logic       o_ovf;

  logic       modelBusy = 1'b0;
  logic       extBusy;
  logic       txMute;
  int         txCnt = 0;
  int         txDoneCount = 0;
  int         startCount = 0;
  int         total = 0;
  int         bad = 0;
  logic       prevPv = 1'b0;

  typedef struct {
    logic [2:0] btn;
    logic [8:0] dx;
    logic [8:0] dy;
    logic       ovf;
  } pkt_t;

  typedef struct {
    logic [7:0] b0;
    logic [7:0] b1;
    logic [7:0] b2;
    pkt_t       exp;
  } vec_t;

  logic [7:0] txExp[$];
  pkt_t       pktExp[$];
  vec_t       vecs[6];

  mouse_ctrl #(
    .TIMEOUT_CYCLES(TO),
    .GAP_CYCLES    (GAP),
    .RETRY_MAX     (RMAX)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_rx_byte  (i_rx_byte),
    .i_rx_valid (i_rx_valid),
    .o_tx_byte  (o_tx_byte),
    .o_tx_start (o_tx_start),
    .i_tx_busy  (i_tx_busy),
    .i_tx_done  (i_tx_done),
    .o_ready    (o_ready),
    .o_err      (o_err),
    .o_pkt_valid(o_pkt_valid),
    .o_btn      (o_btn),
    .o_dx       (o_dx),
    .o_dy       (o_dy),
    .o_ovf      (o_ovf)
  );

  assign i_tx_busy = modelBusy | extBusy;

  // Free-running 100 MHz clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case some wait loop is broken.
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Transmitter model: takes a request, stays busy for a few cycles, then
  // pulses done (unless muted). Also scores every command byte issued.
  always @(negedge clk) begin
    logic busySeen;
    busySeen  = modelBusy | extBusy;
    i_tx_done = 1'b0;
    if (rst_n !== 1'b1) begin
      modelBusy = 1'b0;
      txCnt     = 0;
    end else begin
      if (txCnt > 0) begin
        txCnt--;
        if (txCnt == 0) begin
          modelBusy = 1'b0;
          if (!txMute) begin
            i_tx_done = 1'b1;
            txDoneCount++;
          end
        end
      end
      if (o_tx_start === 1'b1) begin
        startCount++;
        checkOutput("start_not_busy", busySeen, 1'b0);
        checkOutput("tx_expected", txExp.size() != 0, 1'b1);
        if (txExp.size() != 0) checkOutput("tx_byte", o_tx_byte, txExp.pop_front());
        modelBusy = 1'b1;
        txCnt     = 4;
      end
    end
  end

  // Packet scoreboard: every pulse must match the oldest expected report
  // and must last only one cycle.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && o_pkt_valid === 1'b1) begin
      pkt_t e;
      checkOutput("pv_width", prevPv, 1'b0);
      checkOutput("pkt_expected", pktExp.size() != 0, 1'b1);
      if (pktExp.size() != 0) begin
        e = pktExp.pop_front();
        checkOutput("pkt_btn", o_btn, e.btn);
        checkOutput("pkt_dx", o_dx, e.dx);
        checkOutput("pkt_dy", o_dy, e.dy);
        checkOutput("pkt_ovf", o_ovf, e.ovf);
      end
    end
    prevPv = (rst_n === 1'b1) ? o_pkt_valid : 1'b0;
  end

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Present one received byte for exactly one clock.
  task automatic applyStimulus(input logic [7:0] b);
    @(negedge clk);
    i_rx_byte  = b;
    i_rx_valid = 1'b1;
    @(negedge clk);
    i_rx_valid = 1'b0;
  endtask

  task automatic waitTxDone();
    int c0 = txDoneCount;
    int n  = 0;
    while (txDoneCount == c0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checkOutput("tx_done_wait", txDoneCount != c0, 1'b1);
  endtask

  task automatic doReset(input bit expectStart);
    @(negedge clk);
    rst_n = 1'b0;
    waitCycles(2);
    checkOutput("reset_outputs",
                {o_tx_byte, o_tx_start, o_ready, o_err, o_pkt_valid, o_btn, o_dx, o_dy, o_ovf},
                64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    if (expectStart) begin
      @(negedge clk);
      checkOutput("first_start", o_tx_start, 1'b1);
    end
  endtask

  task automatic doInit();
    waitTxDone();
    applyStimulus(8'hFA);
    applyStimulus(8'hAA);
    applyStimulus(8'h00);
    waitTxDone();
    applyStimulus(8'hFA);
    checkOutput("init_ready", o_ready, 1'b1);
    checkOutput("init_err", o_err, 1'b0);
  endtask

  initial begin
    int s0;
    int c;

    vecs[0] = '{8'h29, 8'h05, 8'hFE, '{3'b001, 9'h005, 9'h1FE, 1'b0}};
    vecs[1] = '{8'h19, 8'h05, 8'hFE, '{3'b001, 9'h105, 9'h0FE, 1'b0}};
    vecs[2] = '{8'h0E, 8'h7F, 8'h80, '{3'b110, 9'h07F, 9'h080, 1'b0}};
    vecs[3] = '{8'h3F, 8'hFF, 8'hFF, '{3'b111, 9'h1FF, 9'h1FF, 1'b0}};
    vecs[4] = '{8'h88, 8'h12, 8'h34, '{3'b000, 9'h000, 9'h000, 1'b1}};
    vecs[5] = '{8'h0C, 8'h00, 8'h01, '{3'b100, 9'h000, 9'h001, 1'b0}};

    rst_n      = 1'b0;
    i_rx_byte  = 8'h00;
    i_rx_valid = 1'b0;
    extBusy    = 1'b1;
    txMute     = 1'b0;

    // Clean init with the transmitter initially busy: no request until idle.
    txExp.push_back(8'hFF);
    txExp.push_back(8'hF4);
    doReset(1'b0);
    s0 = startCount;
    waitCycles(10);
    checkOutput("no_start_while_busy", startCount - s0, 0);
    extBusy = 1'b0;
    doInit();
    checkOutput("init_two_starts", startCount - s0, 2);

    // Table of stream packets.
    for (int i = 0; i < 6; i++) begin
      pktExp.push_back(vecs[i].exp);
      applyStimulus(vecs[i].b0);
      applyStimulus(vecs[i].b1);
      applyStimulus(vecs[i].b2);
    end
    waitCycles(3);
    checkOutput("table_pkts_done", pktExp.size(), 0);

    // Unmarked byte is dropped, then an overflow packet zeroes movement.
    pktExp.push_back('{3'b000, 9'h000, 9'h000, 1'b1});
    applyStimulus(8'h00);
    applyStimulus(8'h48);
    applyStimulus(8'h10);
    applyStimulus(8'h10);
    waitCycles(3);
    checkOutput("resync_pkt_done", pktExp.size(), 0);

    // Partial packet abandoned after an idle gap.
    pktExp.push_back('{3'b000, 9'h002, 9'h003, 1'b0});
    applyStimulus(8'h08);
    applyStimulus(8'h01);
    waitCycles(GAP + 10);
    applyStimulus(8'h08);
    applyStimulus(8'h02);
    applyStimulus(8'h03);
    waitCycles(5);
    checkOutput("gap_pkt_done", pktExp.size(), 0);
    checkOutput("hold_dx", o_dx, 9'h002);
    checkOutput("no_cmd_after_ready", startCount - s0, 2);

    // Reset in the middle of a packet, then a full re-init and a packet.
    applyStimulus(8'h08);
    applyStimulus(8'h01);
    txExp.push_back(8'hFF);
    txExp.push_back(8'hF4);
    doReset(1'b1);
    doInit();
    pktExp.push_back('{3'b010, 9'h003, 9'h004, 1'b0});
    applyStimulus(8'h0A);
    applyStimulus(8'h03);
    applyStimulus(8'h04);
    waitCycles(3);
    checkOutput("post_reset_pkt_done", pktExp.size(), 0);

    // Every reset command rejected: RMAX attempts then sticky error.
    for (int i = 0; i < RMAX; i++) txExp.push_back(8'hFF);
    s0 = startCount;
    doReset(1'b1);
    for (int i = 0; i < RMAX; i++) begin
      waitTxDone();
      if (i == RMAX - 1) checkOutput("err_before_last", o_err, 1'b0);
      applyStimulus(8'hFC);
    end
    checkOutput("retry_err", o_err, 1'b1);
    checkOutput("retry_ready", o_ready, 1'b0);
    applyStimulus(8'hFA);
    waitCycles(30);
    checkOutput("retry_starts", startCount - s0, RMAX);
    checkOutput("fail_ignores_rx", o_ready, 1'b0);

    // Silent mouse: each attempt ends on the response timeout.
    for (int i = 0; i < RMAX; i++) txExp.push_back(8'hFF);
    s0 = startCount;
    doReset(1'b1);
    c = 0;
    while (o_err !== 1'b1 && c < RMAX * (TO + 50)) begin
      @(negedge clk);
      c++;
    end
    checkOutput("timeout_err", o_err, 1'b1);
    checkOutput("timeout_duration", c >= RMAX * TO, 1'b1);
    waitCycles(30);
    checkOutput("timeout_starts", startCount - s0, RMAX);
    checkOutput("timeout_ready", o_ready, 1'b0);

    checkOutput("tx_queue_empty", txExp.size(), 0);
    checkOutput("pkt_queue_empty", pktExp.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
